// File: rtl/uart_apb_master.sv
// APB4 initiator: turns one valid/ready command into one APB transfer and returns
// a single response (read data, slave error, timeout) through a held response register.
module uart_apb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy,
    output logic [1:0]  state_o
);

    // Handshakes: a command is taken when cmd_valid & cmd_ready at a rising edge, a
    // response is consumed when rsp_valid & rsp_ready at a rising edge; neither
    // ready depends combinationally on the other side's valid or ready.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic        pwrite_q, pwrite_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pwrite_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pwrite_q      <= pwrite_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pwrite_d      = pwrite_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A new command is only taken once the previous response has drained.
                if (cmd_valid && !rsp_valid_q) begin
                    state_d  = SETUP;
                    wait_d   = '0;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : 4'b0000;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'd0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (TO_EN && (wait_q == TO_LAST)) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE) && !rsp_valid_q;
    assign psel        = (state_q != IDLE);
    assign penable     = (state_q == ACCESS);
    assign busy        = (state_q != IDLE);
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: table of single transfers against a scripted
// APB slave, plus hand-written reset, backpressure and reset-during-transfer sequences.
module tb_uart_apb_master;

    logic        pclk;
    logic        preset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    uart_apb_master #(.TIMEOUT(4)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .busy(busy), .state_o(state_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;      // ACCESS cycles with pready=0 before the ready cycle
        logic [31:0] slv_rdata;
        logic        slv_err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        logic [3:0]  exp_pstrb;
        int          exp_lat;    // edges after the accept edge until rsp_valid is seen
        int          exp_acc;    // number of ACCESS cycles observed
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        int  acc;
        bit  done;
        @(negedge pclk);
        chk({tag, ":cmd_ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        // scramble the command bus to prove the APB fields were registered
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom_range(0, 15));
        cmd_write = ~v.wr;
        chk({tag, ":setup_psel"}, psel, 1);
        chk({tag, ":setup_penable"}, penable, 0);
        chk({tag, ":setup_busy"}, busy, 1);
        chk({tag, ":paddr"}, paddr, v.addr);
        chk({tag, ":pwrite"}, pwrite, v.wr);
        chk({tag, ":pwdata"}, pwdata, v.wdata);
        chk({tag, ":pstrb"}, pstrb, v.exp_pstrb);
        lat  = 0;
        acc  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge pclk);
            lat++;
            @(negedge pclk);
            if (psel && penable) begin
                acc++;
                chk({tag, ":paddr_stable"}, paddr, v.addr);
                chk({tag, ":pwdata_stable"}, pwdata, v.wdata);
                if (acc == v.waits + 1) begin
                    pready  = 1'b1;
                    prdata  = v.slv_rdata;
                    pslverr = v.slv_err;
                end else begin
                    pready  = 1'b0;
                    prdata  = 32'hDEAD_BEEF;
                    pslverr = 1'b1;
                end
            end else begin
                done = 1'b1;
            end
        end
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        chk({tag, ":completed_in_bound"}, done, 1);
        chk({tag, ":latency"}, lat, v.exp_lat);
        chk({tag, ":access_cycles"}, acc, v.exp_acc);
        chk({tag, ":rsp_valid"}, rsp_valid, 1);
        chk({tag, ":rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, ":rsp_err"}, rsp_err, v.exp_err);
        chk({tag, ":rsp_timeout"}, rsp_timeout, v.exp_to);
        chk({tag, ":idle_psel"}, psel, 0);
        chk({tag, ":idle_busy"}, busy, 0);
        chk({tag, ":cmd_ready_rsp_pending"}, cmd_ready, 0);
        @(posedge pclk);
        @(negedge pclk);
        chk({tag, ":rsp_valid_cleared"}, rsp_valid, 0);
        chk({tag, ":cmd_ready_after_rsp"}, cmd_ready, 1);
        chk({tag, ":rsp_rdata_held"}, rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        // wr addr wdata strb waits slv_rdata slv_err | rdata err to pstrb lat acc
        vecs[0] = '{1'b1, 32'h04, 32'h7, 4'hF, 0, 32'h0, 1'b0,
                    32'h0, 1'b0, 1'b0, 4'hF, 2, 1};
        vecs[1] = '{1'b0, 32'h0C, 32'h1111, 4'hF, 3, 32'h5A, 1'b0,
                    32'h5A, 1'b0, 1'b0, 4'h0, 5, 4};
        vecs[2] = '{1'b1, 32'h1C, 32'hAB, 4'h1, 0, 32'h0, 1'b1,
                    32'h0, 1'b1, 1'b0, 4'h1, 2, 1};
        vecs[3] = '{1'b0, 32'h10, 32'h0, 4'h0, 99, 32'hFFFF_FFFF, 1'b0,
                    32'h0, 1'b1, 1'b1, 4'h0, 5, 4};
        vecs[4] = '{1'b0, 32'h14, 32'h0, 4'h0, 3, 32'h0000_A5A5, 1'b0,
                    32'h0000_A5A5, 1'b0, 1'b0, 4'h0, 5, 4};
        vecs[5] = '{1'b1, 32'h08, 32'hCAFE_0001, 4'h3, 1, 32'h1234_5678, 1'b0,
                    32'h0, 1'b0, 1'b0, 4'h3, 3, 2};
        vecs[6] = '{1'b0, 32'h18, 32'h0, 4'hC, 2, 32'h1234, 1'b1,
                    32'h1234, 1'b1, 1'b0, 4'h0, 4, 3};

        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b1;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // reset state
        #3;
        chk("rst:psel", psel, 0);
        chk("rst:penable", penable, 0);
        chk("rst:pwrite", pwrite, 0);
        chk("rst:paddr", paddr, 0);
        chk("rst:pwdata", pwdata, 0);
        chk("rst:pstrb", pstrb, 0);
        chk("rst:rsp_valid", rsp_valid, 0);
        chk("rst:rsp_rdata", rsp_rdata, 0);
        chk("rst:rsp_err", rsp_err, 0);
        chk("rst:rsp_timeout", rsp_timeout, 0);
        chk("rst:busy", busy, 0);
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        chk("rst:cmd_ready", cmd_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // backpressure: response held for 5 cycles while a second command waits
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        rsp_ready = 1'b0;
        pready    = 1'b1;
        prdata    = 32'h42;
        pslverr   = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        cmd_write = 1'b1;
        cmd_addr  = 32'h24;
        cmd_wdata = 32'h99;
        cmd_strb  = 4'hF;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        chk("bp:rsp_valid", rsp_valid, 1);
        chk("bp:rsp_rdata", rsp_rdata, 32'h42);
        repeat (5) begin
            chk("bp:cmd_ready_low", cmd_ready, 0);
            chk("bp:psel_low", psel, 0);
            @(posedge pclk);
            @(negedge pclk);
        end
        chk("bp:rsp_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("bp:rsp_cleared", rsp_valid, 0);
        chk("bp:cmd_ready_up", cmd_ready, 1);
        chk("bp:psel_not_yet", psel, 0);
        chk("bp:rdata_kept", rsp_rdata, 32'h42);
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("bp:second_psel", psel, 1);
        chk("bp:second_paddr", paddr, 32'h24);
        chk("bp:second_pwrite", pwrite, 1);
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        chk("bp:second_rsp", rsp_valid, 1);
        chk("bp:second_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        pready    = 1'b0;
        prdata    = '0;
        @(posedge pclk);
        @(negedge pclk);
        chk("bp:second_drained", rsp_valid, 0);

        // reset asserted in ACCESS drops the bus without a clock edge
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h30;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("rm:in_access", penable, 1);
        #2 preset_n = 1'b0;
        #1;
        chk("rm:psel", psel, 0);
        chk("rm:penable", penable, 0);
        chk("rm:rsp_valid", rsp_valid, 0);
        chk("rm:busy", busy, 0);
        @(negedge pclk);
        preset_n = 1'b1;

        // reset discards a pending response
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h34;
        rsp_ready = 1'b0;
        pready    = 1'b1;
        prdata    = 32'h66;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        chk("rp:pending", rsp_valid, 1);
        #2 preset_n = 1'b0;
        #1;
        chk("rp:rsp_valid", rsp_valid, 0);
        chk("rp:rsp_rdata", rsp_rdata, 0);
        pready    = 1'b0;
        prdata    = '0;
        rsp_ready = 1'b1;
        @(negedge pclk);
        preset_n = 1'b1;

        run_vec('{1'b0, 32'h00, 32'h0, 4'h0, 0, 32'h77, 1'b0,
                  32'h77, 1'b0, 1'b0, 4'h0, 2, 1}, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
